// File: rtl/sequenciador_pkg.sv
// pacote_sequenciador: shared definitions for the sequenciador control FSM.
//   - state encoding (3-bit localparams)
//   - legal opcode constants, shared with the control decoder
//   - pc_src encodings
//   - controle_t: bundle of the control strobes driven by the FSM
//   - opcode_legal(): membership test against the supported opcode set
package pacote_sequenciador;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_FETCH     = 3'd1;
    localparam logic [2:0] ST_DECODE    = 3'd2;
    localparam logic [2:0] ST_EXECUTE   = 3'd3;
    localparam logic [2:0] ST_MEMORY    = 3'd4;
    localparam logic [2:0] ST_WRITEBACK = 3'd5;
    localparam logic [2:0] ST_HALT      = 3'd6;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_SUBI   = 7'b0011111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [1:0] PC_SRC_SEQ = 2'b00;  // PC + 4
    localparam logic [1:0] PC_SRC_IMM = 2'b01;  // PC + imm_ext
    localparam logic [1:0] PC_SRC_ULA = 2'b10;  // ULA result (jalr)

    typedef struct packed {
        logic       mem_req;
        logic       mem_we;
        logic       mem_sel_addr;
        logic       ir_load;
        logic       pc_load;
        logic [1:0] pc_src;
        logic       reg_write;
        logic       instret;
    } controle_t;

    function automatic logic opcode_legal(input logic [6:0] op);
        logic ok;
        case (op)
            OP_R, OP_I, OP_LOAD, OP_STORE, OP_SUBI,
            OP_JAL, OP_JALR, OP_BRANCH, OP_AUIPC: ok = 1'b1;
            default:                              ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/sequenciador_contador_espera.sv
// contador_espera: counts cycles spent waiting for mem_ready.
//   clk     : clock
//   reset   : synchronous active-high reset
//   clear   : zero the count (has priority over enable)
//   enable  : one more waiting cycle elapsed without mem_ready
//   expired : high in the waiting cycle that brings the count to TIMEOUT
module contador_espera #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    // The TIMEOUT-th waiting cycle is the one that sees count == TIMEOUT-1.
    localparam logic [7:0] LIMIT = 8'(TIMEOUT - 1);

    logic [7:0] count_r;

    // Wait-cycle counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_r <= 8'd0;
        end else if (clear) begin
            count_r <= 8'd0;
        end else if (enable) begin
            count_r <= count_r + 8'd1;
        end else begin
            count_r <= count_r;
        end
    end

    assign expired = enable && (count_r == LIMIT);

endmodule

// File: rtl/sequenciador.sv
// sequenciador: multi-cycle control FSM (IDLE/FETCH/DECODE/EXECUTE/MEMORY/
// WRITEBACK/HALT) for a small RISC-V-like datapath.
//   inputs : clk, reset (sync, active-high), start, parar, opcode[6:0],
//            ula_flag, mem_ready
//   outputs: mem_req, mem_we, mem_sel_addr, ir_load, pc_load, pc_src[1:0],
//            reg_write, instret, ocupado, erro
// Strobes are Mealy: they decode from the state plus mem_ready, ula_flag
// and opcode so ir_load/instret land in the same cycle as the event.
module sequenciador
    import pacote_sequenciador::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       parar,
    input  logic [6:0] opcode,
    input  logic       ula_flag,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_we,
    output logic       mem_sel_addr,
    output logic       ir_load,
    output logic       pc_load,
    output logic [1:0] pc_src,
    output logic       reg_write,
    output logic       instret,
    output logic       ocupado,
    output logic       erro
);

    logic [2:0] state_r;
    logic [2:0] next_s;
    logic [2:0] retire_s;
    logic       waiting_s;
    logic       expired_s;
    logic       is_load_s;
    logic       is_store_s;
    controle_t  ctl_s;

    assign is_load_s  = (opcode == OP_LOAD);
    assign is_store_s = (opcode == OP_STORE);
    assign retire_s   = parar ? ST_IDLE : ST_FETCH;
    assign waiting_s  = (state_r == ST_FETCH) || (state_r == ST_MEMORY);

    // Clearing whenever we are not waiting (or the request completes) means
    // the count is always zero on entry to FETCH or MEMORY.
    contador_espera #(.TIMEOUT(TIMEOUT)) u_contador_espera (
        .clk     (clk),
        .reset   (reset),
        .clear   (!waiting_s || mem_ready),
        .enable  (waiting_s && !mem_ready),
        .expired (expired_s)
    );

    // State register; reset overrides every other transition.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_s;
        end
    end

    // Next-state logic.
    always_comb begin
        next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) next_s = ST_FETCH;
                else       next_s = ST_IDLE;
            end
            ST_FETCH: begin
                if (mem_ready)      next_s = ST_DECODE;
                else if (expired_s) next_s = ST_HALT;
                else                next_s = ST_FETCH;
            end
            ST_DECODE: begin
                if (opcode_legal(opcode)) next_s = ST_EXECUTE;
                else                      next_s = ST_HALT;
            end
            ST_EXECUTE: begin
                if (is_load_s || is_store_s)  next_s = ST_MEMORY;
                else if (opcode == OP_BRANCH) next_s = retire_s;
                else                          next_s = ST_WRITEBACK;
            end
            ST_MEMORY: begin
                if (mem_ready && is_store_s) next_s = retire_s;
                else if (mem_ready)          next_s = ST_WRITEBACK;
                else if (expired_s)          next_s = ST_HALT;
                else                         next_s = ST_MEMORY;
            end
            ST_WRITEBACK: next_s = retire_s;
            ST_HALT:      next_s = ST_HALT;
            default:      next_s = ST_HALT;   // unreachable encodings fault
        endcase
    end

    // Control strobe decode.
    always_comb begin
        ctl_s = '0;
        case (state_r)
            ST_FETCH: begin
                ctl_s.mem_req = 1'b1;
                if (mem_ready) ctl_s.ir_load = 1'b1;
                else           ctl_s.ir_load = 1'b0;
            end
            ST_EXECUTE: begin
                if (opcode == OP_BRANCH) begin
                    ctl_s.pc_load = 1'b1;
                    ctl_s.instret = 1'b1;
                    ctl_s.pc_src  = ula_flag ? PC_SRC_IMM : PC_SRC_SEQ;
                end else begin
                    ctl_s.pc_load = 1'b0;
                end
            end
            ST_MEMORY: begin
                ctl_s.mem_req      = 1'b1;
                ctl_s.mem_sel_addr = 1'b1;
                ctl_s.mem_we       = is_store_s;
                if (mem_ready && is_store_s) begin
                    ctl_s.pc_load = 1'b1;
                    ctl_s.pc_src  = PC_SRC_SEQ;
                    ctl_s.instret = 1'b1;
                end else begin
                    ctl_s.pc_load = 1'b0;
                end
            end
            ST_WRITEBACK: begin
                ctl_s.reg_write = 1'b1;
                ctl_s.pc_load   = 1'b1;
                ctl_s.instret   = 1'b1;
                if (opcode == OP_JAL)       ctl_s.pc_src = PC_SRC_IMM;
                else if (opcode == OP_JALR) ctl_s.pc_src = PC_SRC_ULA;
                else                        ctl_s.pc_src = PC_SRC_SEQ;
            end
            default: ctl_s = '0;   // IDLE, DECODE, HALT drive nothing
        endcase
    end

    assign mem_req      = ctl_s.mem_req;
    assign mem_we       = ctl_s.mem_we;
    assign mem_sel_addr = ctl_s.mem_sel_addr;
    assign ir_load      = ctl_s.ir_load;
    assign pc_load      = ctl_s.pc_load;
    assign pc_src       = ctl_s.pc_src;
    assign reg_write    = ctl_s.reg_write;
    assign instret      = ctl_s.instret;
    assign ocupado      = (state_r != ST_IDLE) && (state_r != ST_HALT);
    assign erro         = (state_r == ST_HALT);

endmodule

// File: tb/tb_sequenciador.sv
// tb_sequenciador: directed and randomized instruction streams checked cycle
// by cycle against an instruction-level reference model. The model describes
// each instruction class as its sequence of phases (fetch waits, fetch done,
// decode, execute, memory waits, memory done, writeback) and the strobes each
// phase must show. The DUT uses TIMEOUT=4 so timeouts are reachable quickly.
module tb_sequenciador;

    localparam int TO = 4;

    logic       clk;
    logic       reset;
    logic       start;
    logic       parar;
    logic [6:0] opcode;
    logic       ula_flag;
    logic       mem_ready;
    logic       mem_req;
    logic       mem_we;
    logic       mem_sel_addr;
    logic       ir_load;
    logic       pc_load;
    logic [1:0] pc_src;
    logic       reg_write;
    logic       instret;
    logic       ocupado;
    logic       erro;

    int n_checks = 0;
    int n_pass   = 0;
    bit in_idle  = 1'b1;

    logic [6:0] legal_ops [9] = '{7'b0110011, 7'b0010011, 7'b0000011,
                                  7'b0100011, 7'b0011111, 7'b1101111,
                                  7'b1100111, 7'b1100011, 7'b0010111};

    sequenciador #(.TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .start(start), .parar(parar),
        .opcode(opcode), .ula_flag(ula_flag), .mem_ready(mem_ready),
        .mem_req(mem_req), .mem_we(mem_we), .mem_sel_addr(mem_sel_addr),
        .ir_load(ir_load), .pc_load(pc_load), .pc_src(pc_src),
        .reg_write(reg_write), .instret(instret), .ocupado(ocupado),
        .erro(erro)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected output vector:
    // {mem_req, mem_we, mem_sel_addr, ir_load, pc_load, pc_src, reg_write,
    //  instret, ocupado, erro}
    function automatic logic [10:0] mk(input logic mr, input logic we,
                                       input logic sel, input logic irl,
                                       input logic pcl, input logic [1:0] src,
                                       input logic rw, input logic ir,
                                       input logic oc, input logic er);
        return {mr, we, sel, irl, pcl, src, rw, ir, oc, er};
    endfunction

    localparam logic [10:0] V_ZERO = 11'b000_0000_0000;
    localparam logic [10:0] V_BUSY = 11'b000_0000_0010;
    localparam logic [10:0] V_HALT = 11'b000_0000_0001;

    // Instruction classes as the reference model sees them.
    localparam int C_ALU = 0, C_LOAD = 1, C_STORE = 2, C_BRANCH = 3,
                   C_JAL = 4, C_JALR = 5, C_ILLEGAL = 6;

    function automatic int cls_of(input logic [6:0] op);
        case (op)
            7'b0110011, 7'b0010011, 7'b0011111, 7'b0010111: return C_ALU;
            7'b0000011: return C_LOAD;
            7'b0100011: return C_STORE;
            7'b1100011: return C_BRANCH;
            7'b1101111: return C_JAL;
            7'b1100111: return C_JALR;
            default:    return C_ILLEGAL;
        endcase
    endfunction

    // Compare outputs mid-cycle with the inputs already applied, then advance.
    task automatic step(input string tag, input logic [10:0] exp);
        logic [10:0] obs;
        @(negedge clk);
        obs = {mem_req, mem_we, mem_sel_addr, ir_load, pc_load, pc_src,
               reg_write, instret, ocupado, erro};
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        @(posedge clk);
        #1;
    endtask

    // HALT must hold through a long start request and leave only on reset;
    // reset also wins over a simultaneous start.
    task automatic check_halt();
        for (int i = 0; i < 10; i++) begin
            start     = 1'b1;
            mem_ready = 1'($urandom);
            step("halt_hold", V_HALT);
        end
        reset = 1'b1;
        step("halt_in_reset", V_HALT);
        reset     = 1'b0;
        start     = 1'b0;
        mem_ready = 1'b0;
        step("post_reset_idle", V_ZERO);
        in_idle = 1'b1;
    endtask

    // One instruction. fd/md: waiting cycles before mem_ready in FETCH and
    // MEMORY (>= TO means timeout). stop: parar at retire. rst_phase: 1/2
    // asserts reset (with mem_ready) in FETCH/MEMORY after the waits.
    task automatic run_instr(input logic [6:0] op, input logic flag,
                             input int fd, input int md, input logic stop,
                             input int rst_phase);
        int         c;
        logic [1:0] src;
        c = cls_of(op);
        if (in_idle) begin
            start     = 1'b1;
            mem_ready = 1'($urandom);
            step("idle_start", V_ZERO);
            start   = 1'b0;
            in_idle = 1'b0;
        end
        opcode   = op;
        ula_flag = flag;
        for (int i = 0; i < fd; i++) begin
            mem_ready = 1'b0;
            parar     = 1'($urandom);
            step("fetch_wait", mk(1, 0, 0, 0, 0, 2'b00, 0, 0, 1, 0));
        end
        if (fd >= TO) begin
            check_halt();
            return;
        end
        mem_ready = 1'b1;
        if (rst_phase == 1) begin
            reset = 1'b1;
            step("fetch_in_reset", mk(1, 0, 0, 1, 0, 2'b00, 0, 0, 1, 0));
            reset     = 1'b0;
            mem_ready = 1'b0;
            step("after_reset_fetch", V_ZERO);
            in_idle = 1'b1;
            return;
        end
        step("fetch_done", mk(1, 0, 0, 1, 0, 2'b00, 0, 0, 1, 0));
        mem_ready = 1'($urandom);
        parar     = 1'($urandom);
        step("decode", V_BUSY);
        if (c == C_ILLEGAL) begin
            check_halt();
            return;
        end
        mem_ready = 1'($urandom);
        if (c == C_BRANCH) begin
            parar = stop;
            step("exec_branch",
                 mk(0, 0, 0, 0, 1, flag ? 2'b01 : 2'b00, 0, 1, 1, 0));
        end else begin
            parar = 1'($urandom);
            step("execute", V_BUSY);
            if (c == C_LOAD || c == C_STORE) begin
                for (int i = 0; i < md; i++) begin
                    mem_ready = 1'b0;
                    parar     = 1'($urandom);
                    step("mem_wait", mk(1, c == C_STORE, 1, 0, 0, 2'b00,
                                        0, 0, 1, 0));
                end
                if (md >= TO) begin
                    check_halt();
                    return;
                end
                mem_ready = 1'b1;
                if (rst_phase == 2) begin
                    reset = 1'b1;
                    step("mem_in_reset", mk(1, 0, 1, 0, 0, 2'b00, 0, 0, 1, 0));
                    reset     = 1'b0;
                    mem_ready = 1'b0;
                    step("after_reset_mem", V_ZERO);
                    in_idle = 1'b1;
                    return;
                end
            end
            if (c == C_STORE) begin
                parar = stop;
                step("mem_store", mk(1, 1, 1, 0, 1, 2'b00, 0, 1, 1, 0));
            end else begin
                if (c == C_LOAD) begin
                    parar = 1'($urandom);
                    step("mem_load", mk(1, 0, 1, 0, 0, 2'b00, 0, 0, 1, 0));
                end
                src = (c == C_JAL) ? 2'b01 : ((c == C_JALR) ? 2'b10 : 2'b00);
                mem_ready = 1'($urandom);
                parar     = stop;
                step("writeback", mk(0, 0, 0, 0, 1, src, 1, 1, 1, 0));
            end
        end
        parar = 1'b0;
        if (stop) begin
            mem_ready = 1'($urandom);
            step("idle_after_stop", V_ZERO);
            in_idle = 1'b1;
        end
    endtask

    initial begin
        logic [6:0] op;
        reset = 1'b1; start = 1'b0; parar = 1'b0; opcode = 7'b0000000;
        ula_flag = 1'b0; mem_ready = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b0;
        step("reset_state", V_ZERO);

        // Reset beats start in the same cycle.
        reset = 1'b1; start = 1'b1;
        step("reset_with_start", V_ZERO);
        reset = 1'b0; start = 1'b0;
        step("idle_after_reset_start", V_ZERO);

        // One of each class, one-cycle memory latency, then stops/variants.
        run_instr(7'b0110011, 1'b0, 1, 1, 1'b0, 0);   // R: instret cycle 5
        run_instr(7'b0000011, 1'b0, 1, 1, 1'b0, 0);   // load: cycle 7
        run_instr(7'b0100011, 1'b0, 1, 1, 1'b0, 0);   // store: cycle 6
        run_instr(7'b1100111, 1'b0, 1, 1, 1'b0, 0);   // jalr: pc_src 10
        run_instr(7'b1100011, 1'b1, 1, 1, 1'b0, 0);   // branch taken
        run_instr(7'b1100011, 1'b0, 1, 1, 1'b1, 0);   // branch not taken, stop
        run_instr(7'b1101111, 1'b0, 0, 0, 1'b0, 0);   // jal, ready first cycle
        run_instr(7'b0000011, 1'b1, 0, 0, 1'b1, 0);   // load, zero waits, stop
        run_instr(7'b0010111, 1'b0, 3, 3, 1'b0, 0);   // TO-1 waits: no fault
        run_instr(7'b0100011, 1'b0, 1, 3, 1'b1, 0);   // store, TO-1 mem waits
        run_instr(7'b1111111, 1'b0, 1, 0, 1'b0, 0);   // illegal -> HALT
        run_instr(7'b0110011, 1'b0, TO, 0, 1'b0, 0);  // fetch timeout
        run_instr(7'b0000011, 1'b0, 1, TO, 1'b0, 0);  // memory timeout
        run_instr(7'b0000011, 1'b0, 1, 2, 1'b0, 2);   // reset mid-MEMORY
        run_instr(7'b0010011, 1'b0, 2, 0, 1'b0, 1);   // reset mid-FETCH

        // Randomized stream.
        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(9, 0) == 0) begin
                op = 7'($urandom);
                while (cls_of(op) != C_ILLEGAL) op = 7'($urandom);
            end else begin
                op = legal_ops[$urandom_range(8, 0)];
            end
            run_instr(op, 1'($urandom), int'($urandom_range(3, 0)),
                      int'($urandom_range(3, 0)),
                      $urandom_range(3, 0) == 0, 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
